zebra_rule_checker: RTL

- Parametrised, sequential successor to the fixed 5x5 zebra constraint model.
- Accepts one candidate grid, N_HOUSES rows streamed one house per beat; each row holds N_ATTR attribute values.
- Checks every attribute column is a permutation, then evaluates a runtime-loadable clue table one rule per cycle.
- Returns pass/fail with a failure code and the index of the first failing rule. Used as a hardware oracle beside formal solver benches and for simulation regression of puzzle encodings.

---
 rtl/zebra_pkg.sv | 65 ++++++
 rtl/zebra_rule_eval.sv | 63 ++++++
 rtl/zebra_rule_checker.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/zebra_pkg.sv
// Shared types and helpers for the zebra rule checker: rule/result encodings,
// classic-puzzle value names and a rule-word packer sized for the default build.
package zebra_pkg;

    localparam int DEF_N_HOUSES = 5;
    localparam int DEF_N_ATTR   = 5;
    localparam int DEF_N_RULES  = 16;
    localparam int DEF_VAL_W    = $clog2(DEF_N_HOUSES);
    localparam int DEF_ATTR_W   = $clog2(DEF_N_ATTR);
    localparam int DEF_RULE_W   = 3 + 2 * DEF_ATTR_W + 2 * DEF_VAL_W;

    typedef enum logic [1:0] {
        RT_SAME     = 2'd0,
        RT_RIGHT_OF = 2'd1,
        RT_NEXT_TO  = 2'd2,
        RT_AT_POS   = 2'd3
    } rule_type_e;

    typedef enum logic [1:0] {
        RC_PASS      = 2'd0,
        RC_PERM_ERR  = 2'd1,
        RC_FRAME_ERR = 2'd2,
        RC_RULE_FAIL = 2'd3
    } res_code_e;

    // Attribute column indices of the classic puzzle
    localparam logic [DEF_ATTR_W-1:0] ATTR_NATION = DEF_ATTR_W'(0);
    localparam logic [DEF_ATTR_W-1:0] ATTR_COLOR  = DEF_ATTR_W'(1);
    localparam logic [DEF_ATTR_W-1:0] ATTR_PET    = DEF_ATTR_W'(2);
    localparam logic [DEF_ATTR_W-1:0] ATTR_DRINK  = DEF_ATTR_W'(3);
    localparam logic [DEF_ATTR_W-1:0] ATTR_CIGG   = DEF_ATTR_W'(4);

    typedef enum logic [DEF_VAL_W-1:0] {
        NAT_ENGLISH, NAT_SPAIN, NAT_UKRAIN, NAT_NORWAY, NAT_JAPAN
    } nation_key;

    typedef enum logic [DEF_VAL_W-1:0] {
        COL_RED, COL_GREEN, COL_IVORY, COL_YELLOW, COL_BLUE
    } color_key;

    typedef enum logic [DEF_VAL_W-1:0] {
        PET_DOG, PET_SNAIL, PET_FOX, PET_HORSE, PET_ZEBRA
    } pet_key;

    typedef enum logic [DEF_VAL_W-1:0] {
        DRK_COFFEE, DRK_TEA, DRK_MILK, DRK_JUICE, DRK_WATER
    } drink_key;

    typedef enum logic [DEF_VAL_W-1:0] {
        CIG_OLDGOLD, CIG_KOOLS, CIG_CHESTERFIELD, CIG_LUCKY, CIG_PARLIAMENT
    } cigg_key;

    // Builds a rule word {en, type, attr_a, val_a, attr_b, val_b}
    function automatic logic [DEF_RULE_W-1:0] rule_pack(
        input logic                  en,
        input rule_type_e            rtype,
        input logic [DEF_ATTR_W-1:0] attr_a,
        input logic [DEF_VAL_W-1:0]  val_a,
        input logic [DEF_ATTR_W-1:0] attr_b,
        input logic [DEF_VAL_W-1:0]  val_b
    );
        return {en, rtype, attr_a, val_a, attr_b, val_b};
    endfunction

endpackage

// File: rtl/zebra_rule_eval.sv
// Combinational evaluation of one clue against the looked-up house positions.
// Disabled rules always pass; an enabled rule naming an attribute or value
// outside the grid is treated as failing so a malformed encoding is reported.
module zebra_rule_eval
    import zebra_pkg::*;
#(
    parameter int  N_HOUSES = DEF_N_HOUSES,
    parameter int  N_ATTR   = DEF_N_ATTR,
    localparam int VAL_W    = $clog2(N_HOUSES),
    localparam int ATTR_W   = $clog2(N_ATTR),
    localparam int RULE_W   = 3 + 2 * ATTR_W + 2 * VAL_W
) (
    input  logic [RULE_W-1:0] rule,
    input  logic [VAL_W-1:0]  pa,
    input  logic [VAL_W-1:0]  pb,
    output logic              pass
);

    localparam logic [ATTR_W:0] ATTR_LIM = (ATTR_W + 1)'(N_ATTR);
    localparam logic [VAL_W:0]  VAL_LIM  = (VAL_W + 1)'(N_HOUSES);
    localparam logic [VAL_W:0]  ONE      = (VAL_W + 1)'(1);

    logic              en;
    rule_type_e        rtype;
    logic [ATTR_W-1:0] attr_a;
    logic [VAL_W-1:0]  val_a;
    logic [ATTR_W-1:0] attr_b;
    logic [VAL_W-1:0]  val_b;
    logic              a_ok;
    logic              b_ok;
    logic [VAL_W:0]    pa_x;
    logic [VAL_W:0]    pb_x;

    assign val_b  = rule[VAL_W-1:0];
    assign attr_b = rule[VAL_W +: ATTR_W];
    assign val_a  = rule[VAL_W + ATTR_W +: VAL_W];
    assign attr_a = rule[2 * VAL_W + ATTR_W +: ATTR_W];
    assign rtype  = rule_type_e'(rule[2 * VAL_W + 2 * ATTR_W +: 2]);
    assign en     = rule[RULE_W-1];

    assign a_ok = ({1'b0, attr_a} < ATTR_LIM) && ({1'b0, val_a} < VAL_LIM);
    assign b_ok = ({1'b0, attr_b} < ATTR_LIM) && ({1'b0, val_b} < VAL_LIM);

    // Positions widened by one bit so pa+1 never wraps at the right edge
    assign pa_x = {1'b0, pa};
    assign pb_x = {1'b0, pb};

    // Apply the relation selected by the rule type
    always_comb begin
        pass = 1'b1;
        if (en) begin
            case (rtype)
                RT_SAME:     pass = a_ok && b_ok && (pa == pb);
                RT_RIGHT_OF: pass = a_ok && b_ok && (pb_x == pa_x + ONE);
                RT_NEXT_TO:  pass = a_ok && b_ok &&
                                    ((pb_x == pa_x + ONE) || (pa_x == pb_x + ONE));
                RT_AT_POS:   pass = a_ok && (pa == val_b);
                default:     pass = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/zebra_rule_checker.sv
// Streams one candidate grid row by row, checks every attribute column is a
// permutation and then walks the loadable clue table one rule per cycle,
// reporting pass/fail, a result code and the first failing rule.
module zebra_rule_checker
    import zebra_pkg::*;
#(
    parameter int  N_HOUSES = DEF_N_HOUSES,
    parameter int  N_ATTR   = DEF_N_ATTR,
    parameter int  N_RULES  = DEF_N_RULES,
    localparam int VAL_W    = $clog2(N_HOUSES),
    localparam int ATTR_W   = $clog2(N_ATTR),
    localparam int RULE_W   = 3 + 2 * ATTR_W + 2 * VAL_W,
    localparam int IDX_W    = $clog2(N_RULES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [IDX_W-1:0]          cfg_addr,
    input  logic [RULE_W-1:0]         cfg_data,
    output logic                      cfg_ready,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_ATTR*VAL_W-1:0]   in_row,
    input  logic                      in_last,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [1:0]                res_code,
    output logic [IDX_W-1:0]          res_rule
);

    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_RESULT = 2'd2;

    logic [1:0]                                  state_q, state_d;
    logic [VAL_W-1:0]                            row_q, row_d;
    logic [N_ATTR-1:0][N_HOUSES-1:0]             seen_q, seen_d;
    logic                                        perm_err_q, perm_err_d;
    logic                                        frame_err_q, frame_err_d;
    logic [N_RULES-1:0][RULE_W-1:0]              rules_q, rules_d;
    logic [N_ATTR-1:0][N_HOUSES-1:0][VAL_W-1:0]  pos_q, pos_d;
    logic [IDX_W-1:0]                            rule_idx_q, rule_idx_d;
    logic [1:0]                                  res_code_q, res_code_d;
    logic [IDX_W-1:0]                            res_rule_q, res_rule_d;

    logic [RULE_W-1:0] cur_rule;
    logic [ATTR_W-1:0] cur_attr_a;
    logic [VAL_W-1:0]  cur_val_a;
    logic [ATTR_W-1:0] cur_attr_b;
    logic [VAL_W-1:0]  cur_val_b;
    logic [VAL_W-1:0]  pa;
    logic [VAL_W-1:0]  pb;
    logic              rule_pass;
    logic              row_at_end;

    assign in_ready  = (state_q == S_LOAD);
    assign cfg_ready = (state_q == S_LOAD) && (row_q == '0);
    assign res_valid = (state_q == S_RESULT);
    assign res_code  = res_code_q;
    assign res_rule  = res_rule_q;

    assign cur_val_b  = cur_rule[VAL_W-1:0];
    assign cur_attr_b = cur_rule[VAL_W +: ATTR_W];
    assign cur_val_a  = cur_rule[VAL_W + ATTR_W +: VAL_W];
    assign cur_attr_a = cur_rule[2 * VAL_W + ATTR_W +: ATTR_W];
    assign row_at_end = (int'(row_q) == N_HOUSES - 1);

    // Select the rule under scan and look up both operand positions
    always_comb begin
        cur_rule = '0;
        pa       = '0;
        pb       = '0;
        for (int r = 0; r < N_RULES; r++) begin
            if (int'(rule_idx_q) == r) cur_rule = rules_q[r];
        end
        for (int k = 0; k < N_ATTR; k++) begin
            for (int v = 0; v < N_HOUSES; v++) begin
                if (int'(cur_attr_a) == k && int'(cur_val_a) == v) pa = pos_q[k][v];
                if (int'(cur_attr_b) == k && int'(cur_val_b) == v) pb = pos_q[k][v];
            end
        end
    end

    zebra_rule_eval #(
        .N_HOUSES (N_HOUSES),
        .N_ATTR   (N_ATTR)
    ) u_eval (
        .rule (cur_rule),
        .pa   (pa),
        .pb   (pb),
        .pass (rule_pass)
    );

    // Next-state logic: table writes, row capture, rule scan and result handshake
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        seen_d      = seen_q;
        perm_err_d  = perm_err_q;
        frame_err_d = frame_err_q;
        rules_d     = rules_q;
        pos_d       = pos_q;
        rule_idx_d  = rule_idx_q;
        res_code_d  = res_code_q;
        res_rule_d  = res_rule_q;

        if (cfg_we && cfg_ready) begin
            for (int r = 0; r < N_RULES; r++) begin
                if (int'(cfg_addr) == r) rules_d[r] = cfg_data;
            end
        end

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    for (int k = 0; k < N_ATTR; k++) begin
                        if (int'(in_row[k*VAL_W +: VAL_W]) >= N_HOUSES) perm_err_d = 1'b1;
                        for (int h = 0; h < N_HOUSES; h++) begin
                            if (int'(in_row[k*VAL_W +: VAL_W]) == h) begin
                                if (seen_q[k][h]) perm_err_d = 1'b1;
                                seen_d[k][h] = 1'b1;
                                pos_d[k][h]  = row_q;
                            end
                        end
                    end
                    if (in_last != row_at_end) frame_err_d = 1'b1;
                    if (in_last || row_at_end) begin
                        state_d    = S_CHECK;
                        rule_idx_d = '0;
                    end else begin
                        row_d = row_q + VAL_W'(1);
                    end
                end
            end
            S_CHECK: begin
                if (frame_err_q) begin
                    res_code_d = RC_FRAME_ERR;
                    state_d    = S_RESULT;
                end else if (perm_err_q) begin
                    res_code_d = RC_PERM_ERR;
                    state_d    = S_RESULT;
                end else if (!rule_pass) begin
                    res_code_d = RC_RULE_FAIL;
                    res_rule_d = rule_idx_q;
                    state_d    = S_RESULT;
                end else if (int'(rule_idx_q) == N_RULES - 1) begin
                    res_code_d = RC_PASS;
                    state_d    = S_RESULT;
                end else begin
                    rule_idx_d = rule_idx_q + IDX_W'(1);
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_d     = S_LOAD;
                    row_d       = '0;
                    seen_d      = '0;
                    perm_err_d  = 1'b0;
                    frame_err_d = 1'b0;
                    res_code_d  = RC_PASS;
                    res_rule_d  = '0;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Control state, bitmaps, flags and rule table with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOAD;
            row_q       <= '0;
            seen_q      <= '0;
            perm_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rules_q     <= '0;
            rule_idx_q  <= '0;
            res_code_q  <= RC_PASS;
            res_rule_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            seen_q      <= seen_d;
            perm_err_q  <= perm_err_d;
            frame_err_q <= frame_err_d;
            rules_q     <= rules_d;
            rule_idx_q  <= rule_idx_d;
            res_code_q  <= res_code_d;
            res_rule_q  <= res_rule_d;
        end
    end

    // Position table needs no reset: seen bitmaps gate which entries are meaningful
    always_ff @(posedge clk) begin
        pos_q <= pos_d;
    end

endmodule
